// File: rtl/mix_seq_pkg.sv
// -----------------------------------------------------------------------------
// mix_seq_pkg
// Shared types and helpers for the mix_sequencer valve sequencer.
//   state_t        : sequencer phase encoding
//   chan_sel_t     : result of an inlet search (valid flag + channel index)
//   next_nonzero() : lowest inlet at or above a start index with a nonzero dose
//   resolve_phase(): skips zero-length timed phases in a single transition
// -----------------------------------------------------------------------------
package mix_seq_pkg;

  // Upper bound on the inlet count; the search mask is sized to this so the
  // helpers stay independent of the instance parameters (N_SOLN must not exceed it).
  localparam int MAX_SOLN = 32;
  // One extra bit so "last channel + 1" is representable without wrapping.
  localparam int IDX_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DOSE    = 3'd1,
    ST_TRANSIT = 3'd2,
    ST_MIX     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } chan_sel_t;

  // Lowest index >= from_idx whose bit in nz_mask is set (bit i = dose i nonzero).
  function automatic chan_sel_t next_nonzero(input logic [MAX_SOLN-1:0] nz_mask,
                                             input logic [IDX_W-1:0]    from_idx);
    chan_sel_t sel;
    sel.valid = 1'b0;
    sel.idx   = '0;
    // Walk downwards so the lowest qualifying index is the one left standing.
    for (int i = MAX_SOLN - 1; i >= 0; i--) begin
      if (nz_mask[i] && (IDX_W'(i) >= from_idx)) begin
        sel.valid = 1'b1;
        sel.idx   = IDX_W'(i);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Falls through TRANSIT -> MIX -> DRAIN -> IDLE past any phase whose
  // programmed length is zero, so a zero-length phase costs no cycles.
  function automatic state_t resolve_phase(input state_t want,
                                           input logic   tr_nz,
                                           input logic   mx_nz,
                                           input logic   dr_nz);
    state_t s;
    s = want;
    if ((s == ST_TRANSIT) && !tr_nz) s = ST_MIX;     else s = s;
    if ((s == ST_MIX)     && !mx_nz) s = ST_DRAIN;   else s = s;
    if ((s == ST_DRAIN)   && !dr_nz) s = ST_IDLE;    else s = s;
    return s;
  endfunction

endpackage

// File: rtl/mix_sequencer_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter shared by every timed phase of the sequencer.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : load i_value this cycle (takes priority over counting)
//   i_value   : phase length in cycles
//   o_expire  : high on the last cycle of the loaded length (count == 1)
// The counter saturates at zero rather than wrapping.
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  // Count register: load, else decrement down to zero and stay there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/mix_sequencer.sv
// -----------------------------------------------------------------------------
// mix_sequencer
// Valve sequencer for a serial-mixing chain: meters each inlet in turn, waits
// for transit through the delay lines, holds a mix dwell, then drains.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse, begins a run from IDLE (ignored with abort)
//   abort        : level, forces DRAIN from DOSE/TRANSIT/MIX
//   dose_cfg     : per-inlet dose cycles, field i = [i*CNT_W +: CNT_W]
//   transit_cfg  : transit wait cycles
//   mix_cfg      : mix dwell cycles
//   drain_cfg    : outlet-open cycles
//   inlet_valve  : one-hot-or-zero inlet enables (registered)
//   outlet_valve : outlet enable (registered)
//   busy         : high outside IDLE
//   done         : one-cycle pulse on normal completion
//   aborted      : one-cycle pulse on completion after an abort
// All configuration is captured when start is accepted.
// -----------------------------------------------------------------------------
module mix_sequencer
  import mix_seq_pkg::*;
#(
  parameter int N_SOLN = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [N_SOLN*CNT_W-1:0] dose_cfg,
  input  logic [CNT_W-1:0]        transit_cfg,
  input  logic [CNT_W-1:0]        mix_cfg,
  input  logic [CNT_W-1:0]        drain_cfg,
  output logic [N_SOLN-1:0]       inlet_valve,
  output logic                    outlet_valve,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  state_t                  r_state, w_next_state;
  logic [IDX_W-1:0]        r_chan, w_next_chan;
  logic [N_SOLN*CNT_W-1:0] r_dose;
  logic [CNT_W-1:0]        r_transit, r_mix, r_drain;
  logic                    r_abort_seen;

  logic [N_SOLN-1:0]       r_inlet;
  logic                    r_outlet, r_busy, r_done, r_aborted;

  logic                    w_accept, w_advance, w_abort_take, w_finish, w_abort_any;
  logic                    w_expire;
  logic [N_SOLN*CNT_W-1:0] w_dose_src;
  logic [CNT_W-1:0]        w_transit_src, w_mix_src, w_drain_src, w_load_value;
  logic                    w_tr_nz, w_mx_nz, w_dr_nz;
  logic [MAX_SOLN-1:0]     w_nz_mask;
  chan_sel_t               w_first_sel, w_step_sel;
  logic [N_SOLN-1:0]       w_inlet_next;

  // On the accepting cycle the live inputs drive decisions; afterwards the
  // latched copies do, so host writes mid-run cannot disturb the run.
  assign w_accept      = (r_state == ST_IDLE) && start && !abort;
  assign w_dose_src    = w_accept ? dose_cfg    : r_dose;
  assign w_transit_src = w_accept ? transit_cfg : r_transit;
  assign w_mix_src     = w_accept ? mix_cfg     : r_mix;
  assign w_drain_src   = w_accept ? drain_cfg   : r_drain;
  assign w_tr_nz       = |w_transit_src;
  assign w_mx_nz       = |w_mix_src;
  assign w_dr_nz       = |w_drain_src;

  // Build the nonzero-dose mask that drives the channel search.
  always_comb begin
    w_nz_mask = '0;
    for (int i = 0; i < N_SOLN; i++) begin
      w_nz_mask[i] = |w_dose_src[i*CNT_W +: CNT_W];
    end
  end

  assign w_first_sel = next_nonzero(w_nz_mask, '0);
  assign w_step_sel  = next_nonzero(w_nz_mask, r_chan + IDX_W'(1));

  // Next-state logic; w_advance reloads the shared timer on every transition.
  always_comb begin
    w_next_state = r_state;
    w_next_chan  = r_chan;
    w_advance    = 1'b0;
    w_abort_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_advance = 1'b1;
          if (w_first_sel.valid) begin
            w_next_state = ST_DOSE;
            w_next_chan  = w_first_sel.idx;
          end else begin
            w_next_state = resolve_phase(ST_TRANSIT, w_tr_nz, w_mx_nz, w_dr_nz);
          end
        end else begin
          w_advance = 1'b0;
        end
      end
      ST_DOSE: begin
        if (abort) begin
          w_abort_take = 1'b1;
          w_advance    = 1'b1;
          w_next_state = resolve_phase(ST_DRAIN, w_tr_nz, w_mx_nz, w_dr_nz);
        end else if (w_expire) begin
          w_advance = 1'b1;
          // Jump straight to the next nonzero inlet: no gap cycle.
          if (w_step_sel.valid) begin
            w_next_chan = w_step_sel.idx;
          end else begin
            w_next_state = resolve_phase(ST_TRANSIT, w_tr_nz, w_mx_nz, w_dr_nz);
          end
        end else begin
          w_advance = 1'b0;
        end
      end
      ST_TRANSIT: begin
        if (abort) begin
          w_abort_take = 1'b1;
          w_advance    = 1'b1;
          w_next_state = resolve_phase(ST_DRAIN, w_tr_nz, w_mx_nz, w_dr_nz);
        end else if (w_expire) begin
          w_advance    = 1'b1;
          w_next_state = resolve_phase(ST_MIX, w_tr_nz, w_mx_nz, w_dr_nz);
        end else begin
          w_advance = 1'b0;
        end
      end
      ST_MIX: begin
        if (abort) begin
          w_abort_take = 1'b1;
          w_advance    = 1'b1;
          w_next_state = resolve_phase(ST_DRAIN, w_tr_nz, w_mx_nz, w_dr_nz);
        end else if (w_expire) begin
          w_advance    = 1'b1;
          w_next_state = resolve_phase(ST_DRAIN, w_tr_nz, w_mx_nz, w_dr_nz);
        end else begin
          w_advance = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Abort is deliberately ignored here: the chain is already draining.
        if (w_expire) begin
          w_advance    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_advance = 1'b0;
        end
      end
      default: begin
        w_advance    = 1'b1;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Length of the phase (or dose channel) being entered.
  always_comb begin
    w_load_value = '0;
    case (w_next_state)
      ST_DOSE: begin
        for (int i = 0; i < N_SOLN; i++) begin
          w_load_value = (w_next_chan == IDX_W'(i)) ? w_dose_src[i*CNT_W +: CNT_W]
                                                    : w_load_value;
        end
      end
      ST_TRANSIT: w_load_value = w_transit_src;
      ST_MIX:     w_load_value = w_mix_src;
      ST_DRAIN:   w_load_value = w_drain_src;
      default:    w_load_value = '0;
    endcase
  end

  // Decode the inlet enables from the state being entered so valves are registered.
  always_comb begin
    w_inlet_next = '0;
    for (int i = 0; i < N_SOLN; i++) begin
      w_inlet_next[i] = (w_next_state == ST_DOSE) && (w_next_chan == IDX_W'(i));
    end
  end

  // A start with everything zero completes from IDLE in one step.
  assign w_finish    = (w_next_state == ST_IDLE) && ((r_state != ST_IDLE) || w_accept);
  assign w_abort_any = r_abort_seen || w_abort_take;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_advance),
    .i_value  (w_load_value),
    .o_expire (w_expire)
  );

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_chan       <= '0;
      r_dose       <= '0;
      r_transit    <= '0;
      r_mix        <= '0;
      r_drain      <= '0;
      r_abort_seen <= 1'b0;
      r_inlet      <= '0;
      r_outlet     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_chan  <= w_next_chan;
      if (w_accept) begin
        r_dose    <= dose_cfg;
        r_transit <= transit_cfg;
        r_mix     <= mix_cfg;
        r_drain   <= drain_cfg;
      end else begin
        r_dose    <= r_dose;
        r_transit <= r_transit;
        r_mix     <= r_mix;
        r_drain   <= r_drain;
      end
      r_abort_seen <= w_finish ? 1'b0 : w_abort_any;
      r_inlet      <= w_inlet_next;
      r_outlet     <= (w_next_state == ST_DRAIN);
      r_busy       <= (w_next_state != ST_IDLE);
      r_done       <= w_finish && !w_abort_any;
      r_aborted    <= w_finish && w_abort_any;
    end
  end

  assign inlet_valve  = r_inlet;
  assign outlet_valve = r_outlet;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;

endmodule

// File: tb/tb_mix_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mix_sequencer
// Directed self-checking bench for mix_sequencer (N_SOLN=3, CNT_W=16).
// Cycle t is the interval after the t-th rising edge following the edge that
// samples start; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mix_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [47:0] dose_cfg;
  logic [15:0] transit_cfg;
  logic [15:0] mix_cfg;
  logic [15:0] drain_cfg;
  logic [2:0]  inlet_valve;
  logic        outlet_valve;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_total = 0;
  int n_pass  = 0;
  logic mon_en = 1'b0;

  mix_sequencer #(.N_SOLN(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .dose_cfg     (dose_cfg),
    .transit_cfg  (transit_cfg),
    .mix_cfg      (mix_cfg),
    .drain_cfg    (drain_cfg),
    .inlet_valve  (inlet_valve),
    .outlet_valve (outlet_valve),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input int t, input logic [2:0] e_in,
                            input logic e_out, input logic e_busy,
                            input logic e_done, input logic e_abt);
    check($sformatf("%s_inlet@%0d", tag, t),   32'(inlet_valve),  32'(e_in));
    check($sformatf("%s_outlet@%0d", tag, t),  32'(outlet_valve), 32'(e_out));
    check($sformatf("%s_busy@%0d", tag, t),    32'(busy),         32'(e_busy));
    check($sformatf("%s_done@%0d", tag, t),    32'(done),         32'(e_done));
    check($sformatf("%s_aborted@%0d", tag, t), 32'(aborted),      32'(e_abt));
  endtask

  // Drives configuration and the start pulse during cycle 0.
  task automatic start_run(input logic [47:0] d, input logic [15:0] tr,
                           input logic [15:0] mx, input logic [15:0] dr);
    @(negedge clk);
    dose_cfg    = d;
    transit_cfg = tr;
    mix_cfg     = mx;
    drain_cfg   = dr;
    start       = 1'b1;
  endtask

  // Valve and handshake invariants, checked every cycle once reset has settled.
  always @(negedge clk) begin
    if (mon_en) begin
      n_total++;
      assert ($onehot0(inlet_valve)) n_pass++;
      else $error("FAIL inv_onehot: observed=%0b expected=onehot0", inlet_valve);
      n_total++;
      assert (!((|inlet_valve) && outlet_valve)) n_pass++;
      else $error("FAIL inv_in_out: observed=%0b/%0b expected=not both", inlet_valve, outlet_valve);
      n_total++;
      assert (!(done && aborted)) n_pass++;
      else $error("FAIL inv_done_abt: observed=%0b/%0b expected=not both", done, aborted);
    end
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    dose_cfg    = 48'd0;
    transit_cfg = 16'd0;
    mix_cfg     = 16'd0;
    drain_cfg   = 16'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_outs("reset", 0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    rst    = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal run: doses {4,2,3}, transit 5, mix 6, drain 2
    start_run({16'd3, 16'd2, 16'd4}, 16'd5, 16'd6, 16'd2);
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("nominal", t,
                 (t <= 4) ? 3'b001 : (t <= 6) ? 3'b010 : (t <= 9) ? 3'b100 : 3'b000,
                 (t == 21) || (t == 22), (t <= 22), (t == 23), 1'b0);
    end

    // Zero-dose channel skipped: doses {3,0,2}, transit 1, mix 1, drain 1
    start_run({16'd2, 16'd0, 16'd3}, 16'd1, 16'd1, 16'd1);
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("skip", t,
                 (t <= 3) ? 3'b001 : (t <= 5) ? 3'b100 : 3'b000,
                 (t == 8), (t <= 8), (t == 9), 1'b0);
    end

    // All doses zero, transit 0, mix 0, drain 1
    start_run(48'd0, 16'd0, 16'd0, 16'd1);
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("allzero", t, 3'b000, (t == 1), (t == 1), (t == 2), 1'b0);
    end

    // Abort during MIX: doses {1,0,0}, transit 1, mix 5, drain 3
    start_run({16'd0, 16'd0, 16'd1}, 16'd1, 16'd5, 16'd3);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("abort", t, (t == 1) ? 3'b001 : 3'b000,
                 (t >= 5) && (t <= 7), (t <= 7), 1'b0, (t == 8));
      abort = (t == 4);
    end

    // Start re-pulsed mid-DOSE while the config changes: run unaffected
    start_run({16'd2, 16'd2, 16'd2}, 16'd1, 16'd1, 16'd1);
    for (int t = 1; t <= 11; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("restart", t,
                 (t <= 2) ? 3'b001 : (t <= 4) ? 3'b010 : (t <= 6) ? 3'b100 : 3'b000,
                 (t == 9), (t <= 9), (t == 10), 1'b0);
      if (t == 3) begin
        start       = 1'b1;
        dose_cfg    = {16'd1, 16'd1, 16'd1};
        transit_cfg = 16'd2;
      end else begin
        start = 1'b0;
      end
    end

    // The changed config takes effect on the following run
    start_run({16'd1, 16'd1, 16'd1}, 16'd2, 16'd1, 16'd1);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("newcfg", t,
                 (t == 1) ? 3'b001 : (t == 2) ? 3'b010 : (t == 3) ? 3'b100 : 3'b000,
                 (t == 7), (t <= 7), (t == 8), 1'b0);
    end

    // Reset mid-DRAIN: doses {1,0,0}, transit 0, mix 0, drain 4
    start_run({16'd0, 16'd0, 16'd1}, 16'd0, 16'd0, 16'd4);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      start = 1'b0;
      check_outs("rstmid", t, (t == 1) ? 3'b001 : 3'b000,
                 (t == 2) || (t == 3), (t <= 3), 1'b0, 1'b0);
      rst = (t == 3);
    end

    // Start together with abort in IDLE is ignored
    @(negedge clk);
    dose_cfg = {16'd1, 16'd1, 16'd1};
    start    = 1'b1;
    abort    = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_outs("idleabort", t, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mix_sequencer.md
Name: mix_sequencer

Overview:
- Clocked valve sequencer for a parametrised serial-mixing chain. It generalises the fixed three-solution serpentine/diffmix network to N_SOLN inlets.
- It meters each inlet solution in turn for a programmed number of cycles, waits a programmed transit time for the serpentine delay lines, holds for a mix dwell, then opens the outlet to drain.
- It sits between the host control registers and the chip's pneumatic valve drivers.

Parameters:
- N_SOLN, 3, number of inlet solutions/valves (≥1)
- CNT_W, 16, width of every duration counter and config field

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run when in IDLE
- abort  in  1  level; forces a drain from any active state
- dose_cfg  in  N_SOLN*CNT_W  per-inlet dose cycles; field i = bits [i*CNT_W +: CNT_W]
- transit_cfg  in  CNT_W  cycles to wait after the last dose
- mix_cfg  in  CNT_W  mix dwell cycles
- drain_cfg  in  CNT_W  outlet-open cycles
- inlet_valve  out  N_SOLN  one-hot-or-zero inlet valve enables
- outlet_valve  out  1  outlet valve enable
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse when a run completes normally
- aborted  out  1  single-cycle pulse when a run ends through abort

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Under reset all outputs are 0, the state is IDLE and all counters are 0.
- States: IDLE, DOSE, TRANSIT, MIX, DRAIN.
- Config latch: all *_cfg inputs are captured on the cycle start is accepted. Later changes to the inputs have no effect on a run in progress.
- IDLE:
  - start=1 and abort=0 → go to DOSE with chan = first index whose dose is nonzero.
  - If every dose is 0 → go straight to TRANSIT.
  - start while busy is ignored.
- DOSE:
  - inlet_valve[chan]=1; all other bits are 0.
  - The counter loads the dose value on entry and decrements each cycle. The valve is open for exactly dose[chan] cycles.
  - At count expiry, advance to the next higher index with a nonzero dose, with no gap cycle. Zero-dose channels are skipped in 0 cycles.
  - After the last channel → TRANSIT.
- TRANSIT: all valves closed for transit_cfg cycles, then → MIX.
- MIX: all valves closed for mix_cfg cycles, then → DRAIN.
- DRAIN: outlet_valve=1 for drain_cfg cycles. On the last DRAIN cycle the next state is IDLE, and done pulses on the first IDLE cycle.
- Zero-length timed states: a value of 0 in transit_cfg, mix_cfg or drain_cfg makes that state last 0 cycles; the FSM skips it in the same transition. With drain_cfg=0, done pulses on the cycle after the last nonzero phase.
- Valve invariants:
  - inlet_valve is never more than one-hot.
  - inlet_valve and outlet_valve are never high together.
  - Valve outputs are registered, so each valve changes exactly at a state or channel boundary.
- Latency: start at cycle 0 → first valve asserted at cycle 1.
- abort:
  - In DOSE, TRANSIT or MIX, abort closes all inlet valves next cycle and enters DRAIN with the latched drain_cfg.
  - In DRAIN, abort has no effect.
  - A run that passed through an abort ends with an aborted pulse instead of done.
  - abort in IDLE is ignored, and start in the same cycle is also ignored.
- Counter width: counters are CNT_W bits, unsigned, with no wrap. The maximum dose is 2^CNT_W−1 cycles.
- Reset mid-run: reset has priority over all other inputs. Valves close immediately at the next edge, and neither done nor aborted pulses.

Decomposition:
- Package mix_seq_pkg:
  - state enum (IDLE, DOSE, TRANSIT, MIX, DRAIN)
  - function next_nonzero(dose vector, from index), returning an index and a valid flag
- One sub-module, phase_timer: loadable down-counter with load, value, and an expire output; CNT_W parameter. Instantiated once and shared by all timed phases.

Test Plan:
- N_SOLN=3, doses {4,2,3}, transit=5, mix=6, drain=2, start at t0:
  - inlet_valve = 001 for t1–t4, 010 for t5–t6, 100 for t7–t9
  - all valves closed t10–t20
  - outlet_valve high t21–t22
  - done pulses at t23
  - busy high t1–t22
- Doses {3,0,2}: channel 1 never opens; 001 for 3 cycles is followed immediately by 100 for 2 cycles.
- All doses 0, transit=0, mix=0, drain=1: outlet_valve high only at t1; done pulses at t2.
- abort asserted during MIX: next cycle outlet_valve=1 for drain_cfg cycles, then aborted pulses once; done stays 0.
- start re-pulsed mid-DOSE while dose_cfg changes: no restart and no timing change; dose_cfg applied on the next run. Separately, rst asserted mid-DRAIN: all outputs 0 next cycle and no done pulse.
- Assertions over all tests:
  - inlet_valve is never more than one-hot.
  - inlet_valve and outlet_valve are never high together.
  - done and aborted are never high together.
